ras_ptr_ctrl: RTL
=================

RAS_PTR_CTRL -- requirements
Module: ras_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 40: return-address width.
REQ-002 SHALL have parameter DEPTH, default 32: stack entries; power of two; pointer width PW = log2(DEPTH) = 5.
REQ-003 SHALL have parameter NCKPT, default 8: checkpoint slots; tag width TW = log2(NCKPT) = 3.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port io_push  in  1  call predicted this cycle.
REQ-007 SHALL have port io_push_addr  in  ADDR_W  return address to push.
REQ-008 SHALL have port io_pop  in  1  return predicted this cycle.
REQ-009 SHALL have port io_ckpt_valid  in  1  snapshot pointer state into a slot.
REQ-010 SHALL have port io_ckpt_tag  in  TW  slot for the snapshot.
REQ-011 SHALL have port io_restore_valid  in  1  mispredict; restore from slot.
REQ-012 SHALL have port io_restore_tag  in  TW  slot to restore from.
REQ-013 SHALL have port io_read_idx  out  PW  stack-storage read index (current top, tos).
REQ-014 SHALL have port io_write_valid  out  1  stack-storage write enable.
REQ-015 SHALL have port io_write_idx  out  PW  stack-storage write index.
REQ-016 SHALL have port io_write_addr  out  ADDR_W  stack-storage write data.
REQ-017 SHALL have port io_pred_valid  out  1  registered; storage read data of previous cycle is a usable prediction.

Function
REQ-018 State SHALL be: tos (PW), cnt (0..DEPTH), NCKPT slots {valid, tos, cnt}, pred_valid register.
REQ-019 io_read_idx SHALL equal tos directly (no extra latency); storage supplies data one cycle later.
REQ-020 io_pred_valid SHALL be registered (cnt != 0) of the previous cycle, aligned with one-cycle storage read latency.
REQ-021 Push only: write_valid=1, write_idx=tos+1 mod DEPTH, write_addr=io_push_addr, combinational; next tos=tos+1 (31 wraps to 0); cnt saturates at DEPTH.
REQ-022 Pop only: write_valid=0; next tos=tos-1 (0 wraps to 31).
REQ-023 Push and pop same cycle: write_idx=tos (replace top), next tos and cnt unchanged.
REQ-024 Neither push nor pop: write_valid=0, state unchanged.
REQ-025 Restore with valid slot: next tos/cnt SHALL be slot values; same-cycle push/pop SHALL be ignored and write_valid forced 0.
REQ-026 Restore to slot with valid=0: SHALL be ignored entirely; push/pop proceed normally.
REQ-027 Checkpoint: slot[io_ckpt_tag] SHALL capture pre-update tos/cnt of the current cycle and set valid; restore does not clear valid; same-tag capture and restore same cycle: restore reads old slot contents, slot then overwritten.
REQ-028 io_write_addr SHALL equal io_push_addr whenever write_valid=1; value otherwise don't-care.

Reset
REQ-029 While reset=1: tos=0, cnt=0, all slot valid=0, pred_valid=0 next cycle, io_write_valid forced 0, ckpt/restore ignored.
REQ-030 Reset asserted mid-operation SHALL override any same-cycle push, pop, checkpoint or restore.
REQ-031 Slot tos/cnt payloads need no reset.

Configuration
REQ-032 Macro RAS_UNDERFLOW_GUARD_EN defined: cnt maintained; pop with cnt=0 leaves tos unchanged; pop decrements cnt; push+pop with cnt=0 acts as push only.
REQ-033 Macro undefined: cnt and its slot field absent; pops always move tos; io_pred_valid SHALL be 0 in the cycle after reset and 1 thereafter.

Verification
REQ-034 Reset, push 0x1000 -> write_idx=1, addr 0x1000; next tos=1; pred_valid=1 the following cycle.
REQ-035 33 pushes from reset -> tos wraps 31->0->1; cnt stays 32; write_idx sequence 1..31,0,1.
REQ-036 Guard on: reset then pop -> tos stays 0, pred_valid 0; guard off: tos becomes 31.
REQ-037 tos=5, push 0x2222 and pop together -> write_idx=5, addr 0x2222, tos stays 5.
REQ-038 tos=3 ckpt tag 2, three pushes (tos=6), restore tag 2 with push -> tos=3, write_valid=0; restore tag 7 (never captured) -> ignored.

Source files
------------

// File: rtl/ras_ptr_ctrl.sv
// Return-address-stack pointer controller: owns top-of-stack pointer, fill count
// (when the underflow guard is built in) and mispredict checkpoint slots; drives
// the read/write side of an external stack storage with one-cycle read latency.
//
// Latency: io_read_idx is the current tos (0 cycles); write port is combinational
// from io_push/io_pop; io_pred_valid is registered (aligned with storage read data).
// Backpressure: none; every push/pop/checkpoint/restore is accepted in its cycle.
//
// Ports:
//   clock, reset                       - sole clock, synchronous active-high reset
//   io_push, io_push_addr, io_pop      - predicted call / return this cycle
//   io_ckpt_valid, io_ckpt_tag         - snapshot pre-update pointer state into a slot
//   io_restore_valid, io_restore_tag   - mispredict recovery from a slot
//   io_read_idx                        - storage read index (tos)
//   io_write_valid/_idx/_addr          - storage write port
//   io_pred_valid                      - previous-cycle read data is a usable prediction
//
// Optional feature: define RAS_UNDERFLOW_GUARD_EN to keep a fill count that blocks
// pops from an empty stack and qualifies io_pred_valid.
module ras_ptr_ctrl #(
  parameter int ADDR_W = 40,
  parameter int DEPTH  = 32,
  parameter int NCKPT  = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int TW    = $clog2(NCKPT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_push,
  input  logic [ADDR_W-1:0] io_push_addr,
  input  logic              io_pop,
  input  logic              io_ckpt_valid,
  input  logic [TW-1:0]     io_ckpt_tag,
  input  logic              io_restore_valid,
  input  logic [TW-1:0]     io_restore_tag,
  output logic [PW-1:0]     io_read_idx,
  output logic              io_write_valid,
  output logic [PW-1:0]     io_write_idx,
  output logic [ADDR_W-1:0] io_write_addr,
  output logic              io_pred_valid
);

  logic [PW-1:0]    r_tos;
  logic [NCKPT-1:0] r_slot_vld;
  logic [PW-1:0]    r_slot_tos [NCKPT];
  logic             r_pred_vld;

  logic [PW-1:0]    w_tos_nxt;
  logic [PW-1:0]    w_tos_inc;
  logic [PW-1:0]    w_tos_dec;
  logic             w_restore_hit;
  logic             w_pop_eff;

  assign w_tos_inc     = r_tos + PW'(1);
  assign w_tos_dec     = r_tos - PW'(1);
  // A restore aimed at a never-captured slot is dropped and normal traffic proceeds.
  assign w_restore_hit = io_restore_valid & r_slot_vld[io_restore_tag];

`ifdef RAS_UNDERFLOW_GUARD_EN
  logic [PW:0]      r_cnt;
  logic [PW:0]      r_slot_cnt [NCKPT];
  logic [PW:0]      w_cnt_nxt;

  // Pops on an empty stack are suppressed, so push+pop on empty degrades to push.
  assign w_pop_eff = io_pop & (r_cnt != '0);
`else
  assign w_pop_eff = io_pop;
`endif

  assign io_read_idx   = r_tos;
  assign io_write_addr = io_push_addr;
  assign io_pred_valid = r_pred_vld;

  always_comb begin
    w_tos_nxt      = r_tos;
    io_write_valid = 1'b0;
    io_write_idx   = w_tos_inc;
`ifdef RAS_UNDERFLOW_GUARD_EN
    w_cnt_nxt      = r_cnt;
`endif
    if (reset) begin
      w_tos_nxt = '0;
    end else if (w_restore_hit) begin
      // Recovery wins over any speculative push/pop in the same cycle.
      w_tos_nxt = r_slot_tos[io_restore_tag];
`ifdef RAS_UNDERFLOW_GUARD_EN
      w_cnt_nxt = r_slot_cnt[io_restore_tag];
`endif
    end else if (io_push && w_pop_eff) begin
      // Call and return together: overwrite the current top in place.
      io_write_valid = 1'b1;
      io_write_idx   = r_tos;
    end else if (io_push) begin
      io_write_valid = 1'b1;
      w_tos_nxt      = w_tos_inc;
`ifdef RAS_UNDERFLOW_GUARD_EN
      if (r_cnt != (PW+1)'(DEPTH)) w_cnt_nxt = r_cnt + (PW+1)'(1);
`endif
    end else if (w_pop_eff) begin
      w_tos_nxt = w_tos_dec;
`ifdef RAS_UNDERFLOW_GUARD_EN
      w_cnt_nxt = r_cnt - (PW+1)'(1);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tos      <= '0;
      r_slot_vld <= '0;
      r_pred_vld <= 1'b0;
`ifdef RAS_UNDERFLOW_GUARD_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_tos <= w_tos_nxt;
`ifdef RAS_UNDERFLOW_GUARD_EN
      r_cnt      <= w_cnt_nxt;
      r_pred_vld <= (r_cnt != '0);
`else
      r_pred_vld <= 1'b1;
`endif
      if (io_ckpt_valid) r_slot_vld[io_ckpt_tag] <= 1'b1;
    end
  end

  // Slot payloads carry no reset; their valid bit alone gates use. The restore
  // path reads these registers before this edge, so same-tag capture+restore
  // sees the old snapshot.
  always_ff @(posedge clock) begin
    if (!reset && io_ckpt_valid) begin
      r_slot_tos[io_ckpt_tag] <= r_tos;
`ifdef RAS_UNDERFLOW_GUARD_EN
      r_slot_cnt[io_ckpt_tag] <= r_cnt;
`endif
    end
  end

endmodule
